// File: rtl/dcache_assoc_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dcache_assoc_controller                                       |
// | Purpose  : N-way set-associative write-allocate write-back data cache    |
// |            controller between a CPU load/store port and a DRAM block     |
// |            port, with per-set round-robin replacement and full flush.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dcache_assoc_controller #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 16,
  parameter int WAYS        = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             dcache_address,
  input  logic [WORD_W-1:0]             dcache_data_in,
  input  logic [WORD_W/8-1:0]           dcache_byte_en,
  input  logic                          dcache_rw,
  input  logic                          dcache_valid,
  input  logic                          dcache_flush,
  output logic [WORD_W-1:0]             dcache_data_out,
  output logic                          dcache_data_ready,
  output logic                          dcache_flush_done,
  input  logic [BLOCK_WORDS*WORD_W-1:0] mem_data_in,
  input  logic                          mem_ready,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [BLOCK_WORDS*WORD_W-1:0] mem_data_out,
  output logic                          mem_rw,
  output logic                          mem_valid
);

  localparam int BYTES      = WORD_W / 8;
  localparam int BYTE_OFF_W = $clog2(BYTES);
  localparam int WSEL_W     = $clog2(BLOCK_WORDS);
  localparam int OFF_W      = WSEL_W + BYTE_OFF_W;
  localparam int IDX_W      = $clog2(SETS);
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
  localparam int LOG_WAYS   = $clog2(WAYS);
  localparam int WAY_W      = (WAYS > 1) ? LOG_WAYS : 1;
  localparam int ENTRIES    = SETS * WAYS;
  localparam int ENT_W      = $clog2(ENTRIES);
  localparam int LINE_W     = BLOCK_WORDS * WORD_W;

  typedef enum logic [2:0] {
    S_COMPARE    = 3'd0,
    S_WRITE_BACK = 3'd1,
    S_ALLOCATE   = 3'd2,
    S_FLUSH_SCAN = 3'd3,
    S_FLUSH_WB   = 3'd4
  } state_t;

  // Entries are laid out set-major: entry = set*WAYS + way, which is also the flush scan order.
  logic [TAG_W-1:0]  tag_mem  [ENTRIES];
  logic [LINE_W-1:0] data_mem [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [WAY_W-1:0]  rr_q [SETS];
  logic [WAY_W-1:0]  rr_d [SETS];
  state_t            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [ENT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_word;
  logic [IDX_W-1:0]  flush_idx;
  logic              flush_last;
  logic              hit, inv_found;
  logic [WAY_W-1:0]  hit_way, inv_way, victim_sel;
  logic [ENT_W-1:0]  hit_ent, vic_ent, sel_ent;
  logic              store_we, fill_we;

  function automatic logic [ENT_W-1:0] ent_of(input logic [IDX_W-1:0] idx,
                                              input logic [WAY_W-1:0] way);
    return ENT_W'(int'(idx) * WAYS + int'(way));
  endfunction

  assign req_idx    = IDX_W'(dcache_address >> OFF_W);
  assign req_tag    = TAG_W'(dcache_address >> (OFF_W + IDX_W));
  assign req_word   = WSEL_W'(dcache_address >> BYTE_OFF_W);
  assign flush_idx  = IDX_W'(flush_cnt_q >> LOG_WAYS);
  assign flush_last = (flush_cnt_q == ENT_W'(ENTRIES - 1));
  assign hit_ent    = ent_of(req_idx, hit_way);
  assign vic_ent    = ent_of(req_idx, victim_q);
  assign victim_sel = inv_found ? inv_way : rr_q[req_idx];
  assign sel_ent    = ent_of(req_idx, victim_sel);

  // Tag compare across the ways of the addressed set and lowest-invalid-way search.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[ent_of(req_idx, WAY_W'(w))] &&
          tag_mem[ent_of(req_idx, WAY_W'(w))] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[ent_of(req_idx, WAY_W'(w))]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Next-state, bookkeeping updates and all outputs.
  always_comb begin
    state_d           = state_q;
    victim_d          = victim_q;
    flush_cnt_d       = flush_cnt_q;
    valid_d           = valid_q;
    dirty_d           = dirty_q;
    rr_d              = rr_q;
    store_we          = 1'b0;
    fill_we           = 1'b0;
    dcache_data_out   = '0;
    dcache_data_ready = 1'b0;
    dcache_flush_done = 1'b0;
    mem_address       = '0;
    mem_data_out      = '0;
    mem_rw            = 1'b0;
    mem_valid         = 1'b0;
    case (state_q)
      S_COMPARE: begin
        if (dcache_valid) begin
          if (hit) begin
            dcache_data_ready = 1'b1;
            dcache_data_out   = data_mem[hit_ent][int'(req_word)*WORD_W +: WORD_W];
            if (dcache_rw) begin
              store_we         = 1'b1;
              dirty_d[hit_ent] = 1'b1;
            end
          end else begin
            victim_d = victim_sel;
            // Pointer moves only when a resident line is displaced.
            if (!inv_found) begin
              rr_d[req_idx] = WAY_W'((int'(rr_q[req_idx]) + 1) % WAYS);
            end
            if (valid_q[sel_ent] && dirty_q[sel_ent]) begin
              state_d = S_WRITE_BACK;
            end else begin
              state_d = S_ALLOCATE;
            end
          end
        end else if (dcache_flush) begin
          flush_cnt_d = '0;
          state_d     = S_FLUSH_SCAN;
        end
      end
      S_WRITE_BACK: begin
        mem_valid    = 1'b1;
        mem_rw       = 1'b1;
        mem_address  = {tag_mem[vic_ent], req_idx, {OFF_W{1'b0}}};
        mem_data_out = data_mem[vic_ent];
        if (mem_ready) begin
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        mem_valid   = 1'b1;
        mem_address = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ready) begin
          fill_we          = 1'b1;
          valid_d[vic_ent] = 1'b1;
          dirty_d[vic_ent] = 1'b0;
          state_d          = S_COMPARE;
        end
      end
      S_FLUSH_SCAN: begin
        if (valid_q[flush_cnt_q] && dirty_q[flush_cnt_q]) begin
          state_d = S_FLUSH_WB;
        end else begin
          valid_d[flush_cnt_q] = 1'b0;
          dirty_d[flush_cnt_q] = 1'b0;
          if (flush_last) begin
            dcache_flush_done = 1'b1;
            flush_cnt_d       = '0;
            state_d           = S_COMPARE;
          end else begin
            flush_cnt_d = flush_cnt_q + ENT_W'(1);
          end
        end
      end
      S_FLUSH_WB: begin
        mem_valid    = 1'b1;
        mem_rw       = 1'b1;
        mem_address  = {tag_mem[flush_cnt_q], flush_idx, {OFF_W{1'b0}}};
        mem_data_out = data_mem[flush_cnt_q];
        if (mem_ready) begin
          valid_d[flush_cnt_q] = 1'b0;
          dirty_d[flush_cnt_q] = 1'b0;
          if (flush_last) begin
            dcache_flush_done = 1'b1;
            flush_cnt_d       = '0;
            state_d           = S_COMPARE;
          end else begin
            flush_cnt_d = flush_cnt_q + ENT_W'(1);
            state_d     = S_FLUSH_SCAN;
          end
        end
      end
      default: state_d = S_COMPARE;
    endcase
  end

  // Control state and line status; async reset abandons any miss or flush in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_COMPARE;
      victim_q    <= '0;
      flush_cnt_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      flush_cnt_q <= flush_cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      rr_q        <= rr_d;
    end
  end

  // Tag and data arrays: line fill from DRAM or byte-merged store on a hit.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      data_mem[vic_ent] <= mem_data_in;
      tag_mem[vic_ent]  <= req_tag;
    end else if (store_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (dcache_byte_en[b]) begin
          data_mem[hit_ent][int'(req_word)*WORD_W + b*8 +: 8] <= dcache_data_in[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_assoc_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dcache_assoc_controller                                    |
// | Purpose  : Self-checking bench: directed scenarios plus random traffic   |
// |            against a set/way cache model and a DRAM responder.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dcache_assoc_controller;

  localparam int NSETS = 16;
  localparam int NWAYS = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  dcache_address, dcache_data_in, dcache_data_out;
  logic [3:0]   dcache_byte_en;
  logic         dcache_rw, dcache_valid, dcache_flush;
  logic         dcache_data_ready, dcache_flush_done;
  logic [127:0] mem_data_in, mem_data_out;
  logic         mem_ready, mem_rw, mem_valid;
  logic [31:0]  mem_address;

  dcache_assoc_controller dut (
    .clock(clock), .reset(reset),
    .dcache_address(dcache_address), .dcache_data_in(dcache_data_in),
    .dcache_byte_en(dcache_byte_en), .dcache_rw(dcache_rw),
    .dcache_valid(dcache_valid), .dcache_flush(dcache_flush),
    .dcache_data_out(dcache_data_out), .dcache_data_ready(dcache_data_ready),
    .dcache_flush_done(dcache_flush_done),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_rw(mem_rw), .mem_valid(mem_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } mem_op_t;

  int checks = 0;
  int errors = 0;

  // Reference cache state, one slot per (set, way).
  logic         m_valid [NSETS][NWAYS];
  logic         m_dirty [NSETS][NWAYS];
  logic [23:0]  m_tag   [NSETS][NWAYS];
  logic [127:0] m_line  [NSETS][NWAYS];
  int           m_rr    [NSETS];
  logic [127:0] dram [logic [31:0]];
  mem_op_t      exp_ops [$];

  // DRAM responder state.
  bit      serving;
  int      wait_c;
  int      lat_sum;
  mem_op_t cur_op;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dram_read(input logic [31:0] baddr);
    logic [127:0] l;
    if (dram.exists(baddr)) return dram[baddr];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = baddr * 7 + i + 32'h1000_0000;
    return l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endfunction

  // Cache semantics: predicts DRAM traffic, updates the model, returns the word a load sees.
  function automatic void model_access(input logic [31:0] addr, input logic rw,
                                       input logic [31:0] wdata, input logic [3:0] be,
                                       output logic [31:0] exp_word);
    logic [3:0]  s;
    logic [23:0] t;
    logic [31:0] ba;
    int wd, hw, v;
    s = addr[7:4]; t = addr[31:8]; wd = int'(addr[3:2]); hw = -1;
    for (int i = 0; i < NWAYS; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) hw = i;
    if (hw < 0) begin
      v = -1;
      for (int i = 0; i < NWAYS; i++)
        if (!m_valid[s][i] && v < 0) v = i;
      if (v < 0) begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % NWAYS;
      end
      if (m_valid[s][v] && m_dirty[s][v]) begin
        ba = {m_tag[s][v], s, 4'h0};
        exp_ops.push_back({1'b1, ba, m_line[s][v]});
        dram[ba] = m_line[s][v];
      end
      ba = {t, s, 4'h0};
      exp_ops.push_back({1'b0, ba, dram_read(ba)});
      m_line[s][v]  = dram_read(ba);
      m_tag[s][v]   = t;
      m_valid[s][v] = 1'b1;
      m_dirty[s][v] = 1'b0;
      hw = v;
    end
    if (rw) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_line[s][hw][wd*32 + b*8 +: 8] = wdata[b*8 +: 8];
      m_dirty[s][hw] = 1'b1;
    end
    exp_word = m_line[s][hw][wd*32 +: 32];
  endfunction

  function automatic void model_flush();
    logic [31:0] ba;
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++) begin
        if (m_valid[s][w] && m_dirty[s][w]) begin
          ba = {m_tag[s][w], 4'(s), 4'h0};
          exp_ops.push_back({1'b1, ba, m_line[s][w]});
          dram[ba] = m_line[s][w];
        end
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
  endfunction

  // One cycle of DRAM behaviour, called #1 after a falling edge.
  task automatic mem_step();
    if (serving) begin
      chk("mem_valid_held", mem_valid, 1'b1);
      chk("mem_addr_held", mem_address, cur_op.addr);
    end else if (mem_valid) begin
      if (exp_ops.size() == 0) begin
        chk("unexpected_mem_req", mem_valid, 1'b0);
        cur_op = {mem_rw, mem_address, 128'h0};
      end else begin
        cur_op = exp_ops.pop_front();
        chk("mem_rw", mem_rw, cur_op.rw);
        chk("mem_addr", mem_address, cur_op.addr);
        if (cur_op.rw) chk("wb_data", mem_data_out, cur_op.data);
      end
      wait_c  = $urandom_range(0, 3);
      lat_sum += wait_c + 1;
      serving = 1'b1;
    end
    if (serving) begin
      if (wait_c == 0) begin
        mem_ready   = 1'b1;
        mem_data_in = cur_op.rw ? {$urandom(), $urandom(), $urandom(), $urandom()} : cur_op.data;
        serving     = 1'b0;
      end else begin
        wait_c--;
      end
    end
  endtask

  // Issue one CPU request starting at a falling edge; returns at a falling edge.
  task automatic do_access(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] obs);
    logic [31:0] exp_word;
    int  cyc, n_ops;
    bit  done;
    exp_ops.delete();
    model_access(addr, rw, wdata, be, exp_word);
    n_ops = exp_ops.size();
    lat_sum = 0; serving = 1'b0; done = 1'b0; cyc = 0; obs = '0;
    dcache_address = addr; dcache_rw = rw; dcache_data_in = wdata;
    dcache_byte_en = be; dcache_valid = 1'b1;
    while (!done && cyc < 200) begin
      #1;
      if (dcache_data_ready) begin
        done = 1'b1;
        obs  = dcache_data_out;
        chk("latency", cyc, (n_ops == 0) ? 0 : 1 + lat_sum);
        chk("mem_valid_at_ready", mem_valid, 1'b0);
        chk("ops_left", exp_ops.size(), 0);
        if (!rw) chk("load_data", dcache_data_out, exp_word);
      end else begin
        mem_step();
      end
      @(negedge clock);
      mem_ready = 1'b0;
      cyc++;
    end
    if (!done) chk("access_timeout", done, 1'b1);
    dcache_valid = 1'b0;
  endtask

  task automatic do_flush();
    int  cyc, dones, post;
    exp_ops.delete();
    model_flush();
    lat_sum = 0; serving = 1'b0; cyc = 0; dones = 0; post = 0;
    dcache_valid = 1'b0; dcache_flush = 1'b1;
    while (post < 4 && cyc < 3000) begin
      #1;
      mem_step();
      #1;
      if (dcache_flush_done) dones++;
      @(negedge clock);
      mem_ready = 1'b0; dcache_flush = 1'b0;
      cyc++;
      if (dones > 0) post++;
    end
    chk("flush_done_count", dones, 1);
    chk("flush_ops_left", exp_ops.size(), 0);
  endtask

  initial begin
    logic [31:0] obs, a;
    int cyc;
    reset = 1'b1; dcache_address = '0; dcache_data_in = '0; dcache_byte_en = '0;
    dcache_rw = 1'b0; dcache_valid = 1'b0; dcache_flush = 1'b0;
    mem_data_in = '0; mem_ready = 1'b0; serving = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_ready", dcache_data_ready, 1'b0);
    chk("rst_flush_done", dcache_flush_done, 1'b0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_rw", mem_rw, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_mem_valid", mem_valid, 1'b0);

    // First fill of set 1 with known words.
    dram[32'h010] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    do_access(32'h010, 1'b0, 32'h0, 4'h0, obs);
    chk("load_a0", obs, 32'hA0);
    do_access(32'h014, 1'b1, 32'hDEADBEEF, 4'b0011, obs);
    do_access(32'h014, 1'b0, 32'h0, 4'h0, obs);
    chk("merge_beef", obs, 32'h0000BEEF);

    // Second way of set 1, then a conflict that evicts the dirty line.
    do_access(32'h110, 1'b0, 32'h0, 4'h0, obs);
    do_access(32'h210, 1'b0, 32'h0, 4'h0, obs);
    do_access(32'h310, 1'b0, 32'h0, 4'h0, obs);
    do_access(32'h410, 1'b0, 32'h0, 4'h0, obs);

    // Two dirty lines, flush, then the same addresses miss again.
    do_access(32'h318, 1'b1, 32'h12345678, 4'hF, obs);
    do_access(32'h020, 1'b1, 32'hCAFEF00D, 4'hF, obs);
    do_flush();
    do_access(32'h318, 1'b0, 32'h0, 4'h0, obs);
    chk("post_flush_318", obs, 32'h12345678);
    do_access(32'h020, 1'b0, 32'h0, 4'h0, obs);
    chk("post_flush_020", obs, 32'hCAFEF00D);

    // Reset while the fill is outstanding.
    dcache_address = 32'h5A0; dcache_rw = 1'b0; dcache_valid = 1'b1;
    cyc = 0;
    #1;
    while (!mem_valid && cyc < 10) begin
      @(negedge clock); #1; cyc++;
    end
    chk("rst_mid_req", mem_valid, 1'b1);
    chk("rst_mid_rw", mem_rw, 1'b0);
    chk("rst_mid_addr", mem_address, 32'h5A0);
    reset = 1'b1;
    #1;
    chk("rst_mid_drop", mem_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0; dcache_valid = 1'b0;
    model_reset();
    @(negedge clock);
    do_access(32'h5A0, 1'b0, 32'h0, 4'h0, obs);

    // Random traffic over a small conflict-heavy footprint.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        do_flush();
      end else begin
        a = {24'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
        do_access(a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)), obs);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
